// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bundle for the divider
interface seq_divider_if #(parameter int N = 6);
  logic         start;
  logic         signed_mode;
  logic [2*N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;
  logic         overflow;
  modport master (output start, signed_mode, dividend, divisor,
                  input busy, done, quotient, remainder, div_zero, overflow);
  modport slave (input start, signed_mode, dividend, divisor,
                 output busy, done, quotient, remainder, div_zero, overflow);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring 2N/N divider with signed mode, divide-by-zero and overflow detection
module seq_divider #(parameter int N = 6) (
  input logic clk,
  input logic rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, next;
  logic [N:0]     a, a_sh;
  logic [N-1:0]   q, d, dlo, vm, lim;
  logic [2*N-1:0] dm;
  logic [CW-1:0]  cnt;
  logic           sgn, sign_q, sign_r, zf, of, ge, sovf;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  // operand magnitudes, one restoring step, signed-overflow test and next state
  always_comb begin
    dm = bus.signed_mode && bus.dividend[2*N-1] ? -bus.dividend : bus.dividend;
    vm = bus.signed_mode && bus.divisor[N-1] ? -bus.divisor : bus.divisor;
    a_sh = {a[N-1:0], q[N-1]};
    ge = a_sh >= {1'b0, d};
    lim = {1'b0, {(N-1){1'b1}}} + N'(sign_q);
    sovf = sgn && !zf && !of && q > lim;
    next = state == IDLE ? (bus.start ? ((vm == '0 || dm[2*N-1:N] >= vm) ? FIX : CALC) : IDLE) :
           state == CALC ? (cnt == CW'(1) ? FIX : CALC) : IDLE;
  end
  // datapath: latch on start, iterate in CALC, publish results in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      q <= '0;
      d <= '0;
      dlo <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      zf <= 1'b0;
      of <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_zero <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE && bus.start) begin
        sgn <= bus.signed_mode;
        sign_q <= bus.signed_mode & (bus.dividend[2*N-1] ^ bus.divisor[N-1]);
        sign_r <= bus.signed_mode & bus.dividend[2*N-1];
        a <= {1'b0, dm[2*N-1:N]};
        q <= dm[N-1:0];
        d <= vm;
        dlo <= bus.dividend[N-1:0];
        cnt <= CW'(N);
        zf <= vm == '0;
        of <= vm != '0 && dm[2*N-1:N] >= vm;
        bus.busy <= 1'b1;
        bus.div_zero <= 1'b0;
        bus.overflow <= 1'b0;
      end else if (state == CALC) begin
        a <= ge ? a_sh - {1'b0, d} : a_sh;
        q <= {q[N-2:0], ge};
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.div_zero <= zf;
        bus.overflow <= of | sovf;
        bus.quotient <= (zf | of | sovf) ? '1 : (sign_q ? -q : q);
        bus.remainder <= zf ? dlo : (of | sovf) ? '0 : (sign_r ? -a[N-1:0] : a[N-1:0]);
      end
    end
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised sequential restoring divider: 2N-bit dividend by N-bit divisor gives an N-bit quotient and an N-bit remainder.
- Datapath and controller are integrated, with a start/done handshake.
- Runtime signed/unsigned mode; divide-by-zero and overflow are detected.
- Successor to the fixed 12/6-bit divider datapath; sits as an arithmetic unit beside the multiplier in the processor datapath.

Parameters:
N, 6, divisor/quotient/remainder width; dividend is 2N bits; N >= 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  request; sampled only in IDLE.
signed_mode  input  1  1 = two's-complement operands/results; sampled with start.
dividend  input  2N  sampled with start.
divisor  input  N  sampled with start.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; results valid from this cycle.
quotient  output  N  result; held until next accepted start.
remainder  output  N  result; held until next accepted start.
div_zero  output  1  divisor was 0; valid with done, held.
overflow  output  1  quotient not representable; valid with done, held.

Behaviour:
- Reset: synchronous, active-high, and overrides everything including mid-operation.
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_zero, overflow all go to 0.
  - Any in-flight operation is discarded with no done.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On a clock edge with start=1: latch mode and operands, set busy=1, clear done/div_zero/overflow.
  - In signed mode, convert both operands to magnitudes. Use a 2N-bit magnitude for the dividend and an N-bit unsigned magnitude for the divisor; -2^(N-1) maps to 2^(N-1).
  - Record sign_q = dividend sign XOR divisor sign, and sign_r = dividend sign.
  - If divisor == 0: go straight to FIX with the zero flag.
  - Else if (magnitude dividend[2N-1:N]) >= (magnitude divisor): go straight to FIX with the overflow flag.
  - Else go to CALC with count = N.
- CALC: one quotient bit per cycle.
  - Shift the {A (N+1 bits), Q (N bits)} pair left.
  - Trial-subtract the divisor from A; if the result is non-negative, keep it and set Q[0]=1; else restore A and set Q[0]=0.
  - Decrement count; after N cycles go to FIX.
- FIX: one cycle, then IDLE. On this edge: busy=0, done=1 (done drops to 0 on the next edge).
  - div_zero: quotient = all ones; remainder = dividend[N-1:0]; div_zero = 1.
  - Overflow precheck: quotient = all ones; remainder = 0; overflow = 1.
  - Normal, unsigned: quotient = Q; remainder = A[N-1:0].
  - Normal, signed:
    - Quotient is Q negated if sign_q = 1.
    - Remainder is A negated if sign_r = 1. The result is truncating division: the remainder takes the dividend's sign.
    - Signed overflow if the magnitude of Q > 2^(N-1)-1 with sign_q = 0, or > 2^(N-1) with sign_q = 1. Then overflow = 1, quotient = all ones, remainder = 0.
- Latency, start sampled at edge k:
  - Normal operation: done=1 after edge k+N+1, i.e. N+1 cycles.
  - div_zero or overflow precheck: done=1 after edge k+1.
- start while busy=1 is ignored. start is sampled only in IDLE; the cycle done=1 is IDLE, so back-to-back start in that cycle is accepted.
- Operand changes after the start edge have no effect.
- All arithmetic is exact modular at its stated width; there are no X outputs after reset.

Test Plan:
1. N=6, unsigned, dividend=100, divisor=7, start 1 cycle → busy 1 for 7 cycles; done pulse 7 cycles after start; quotient=14, remainder=2, flags 0.
2. N=6, signed, dividend=-100 (12'hF9C), divisor=7 → quotient=6'b110010 (-14), remainder=6'b111110 (-2), overflow=0; signed, dividend=-100, divisor=-7 → quotient=14, remainder=-2.
3. Unsigned dividend=1000, divisor=7 → done 1 cycle after start, overflow=1, quotient=6'h3F, remainder=0. Signed dividend=1000, divisor=31 → quotient magnitude 32 > 31, so overflow=1 after full latency.
4. divisor=0, dividend=12'h0A5 → done after 1 cycle, div_zero=1, quotient=6'h3F, remainder=6'h25.
5. Start during CALC with different operands → ignored; first result unchanged. New start in the done cycle → accepted, second result correct.
6. rst=1 at CALC cycle 3 → next edge all outputs 0, state IDLE, no done; a subsequent 100/7 completes normally.
